// File: rtl/axi_wdata_fifo_drain_256b_if.sv
// Bundle between the data FIFO drain and its surroundings:
// burst command, FIFO read port and the AXI W channel.
interface axi_wdata_fifo_drain_256b_if #(
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = 32,
  parameter int FIFO_WIDTH = 288,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  fifo_pop;
  logic                  fifo_valid;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wlast;
  logic                  burst_done;
  logic                  busy;

  // master: the drain itself (it masters the W channel)
  modport master (
    input  cmd_valid, cmd_len,
    input  fifo_valid, fifo_data_out, fifo_empty,
    input  m_wready,
    output cmd_ready, fifo_pop,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    output burst_done, busy
  );

  modport slave (
    output cmd_valid, cmd_len,
    output fifo_valid, fifo_data_out, fifo_empty,
    output m_wready,
    input  cmd_ready, fifo_pop,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  burst_done, busy
  );
endinterface

// File: rtl/axi_wdata_fifo_drain_256b.sv
// Drains len+1 entries of the 288b data FIFO onto an AXI W channel,
// hiding the FIFO's 1-cycle read latency in a 2-entry skid buffer.
module axi_wdata_fifo_drain_256b #(
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = 32,
  parameter int FIFO_WIDTH = 288,
  parameter int LEN_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  axi_wdata_fifo_drain_256b_if.master bus
);
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_pop_rem;
  logic [CW-1:0]         r_beat_rem;
  logic                  r_inflight;
  logic [FIFO_WIDTH-1:0] r_d0;
  logic [FIFO_WIDTH-1:0] r_d1;
  logic                  r_v0;
  logic                  r_v1;
  logic                  r_cmd_ready;
  logic                  r_done;

  logic                  w_fire;
  logic                  w_cap;
  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_last_beat;
  logic [FIFO_WIDTH-1:0] w_n_d0;
  logic [FIFO_WIDTH-1:0] w_n_d1;
  logic                  w_n_v0;
  logic                  w_n_v1;

  assign w_fire      = r_v0 & bus.m_wready;
  assign w_cap       = bus.fifo_valid & r_inflight;
  assign w_occ       = 2'(r_v0) + 2'(r_v1) + 2'(r_inflight);
  assign w_last_beat = (r_beat_rem == CW'(1));

  // a pop is safe at occ==2 only if a beat leaves in the same cycle
  assign w_pop = (r_state == S_BURST)
               & (r_pop_rem != '0)
               & ~bus.fifo_empty
               & ((w_occ < 2'd2) | w_fire);

  always_comb begin
    w_n_d0 = r_d0;
    w_n_d1 = r_d1;
    w_n_v0 = r_v0;
    w_n_v1 = r_v1;
    if (w_fire) begin
      w_n_v0 = r_v1;
      w_n_v1 = 1'b0;
      if (r_v1) w_n_d0 = r_d1;
    end
    if (w_cap) begin
      if (!w_n_v0) begin
        w_n_d0 = bus.fifo_data_out;
        w_n_v0 = 1'b1;
      end else begin
        w_n_d1 = bus.fifo_data_out;
        w_n_v1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pop_rem   <= '0;
      r_beat_rem  <= '0;
      r_inflight  <= 1'b0;
      r_d0        <= '0;
      r_d1        <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      r_d0       <= w_n_d0;
      r_d1       <= w_n_d1;
      r_v0       <= w_n_v0;
      r_v1       <= w_n_v1;
      r_done     <= 1'b0;
      if (w_pop) r_pop_rem <= r_pop_rem - CW'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_pop_rem   <= {1'b0, bus.cmd_len} + CW'(1);
            r_beat_rem  <= {1'b0, bus.cmd_len} + CW'(1);
            r_state     <= S_BURST;
            r_cmd_ready <= 1'b0;
          end
        end
        S_BURST: begin
          if (w_fire) begin
            r_beat_rem <= r_beat_rem - CW'(1);
            if (w_last_beat) begin
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.fifo_pop   = w_pop;
  assign bus.m_wvalid   = r_v0;
  assign bus.m_wdata    = r_d0[DATA_WIDTH-1:0];
  assign bus.m_wstrb    = r_d0[DATA_WIDTH +: STRB_WIDTH];
  assign bus.m_wlast    = r_v0 & w_last_beat;
  assign bus.burst_done = r_done;
  assign bus.busy       = (r_state == S_BURST);
endmodule

// File: tb/tb_axi_wdata_fifo_drain_256b.sv
// Directed bench: FIFO model, W-channel scoreboard, burst table
// and hand-written reset sequences.
module tb_axi_wdata_fifo_drain_256b;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_wdata_fifo_drain_256b_if bus ();

  axi_wdata_fifo_drain_256b dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [287:0] act,
                              logic [287:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  logic [287:0] pend[$];
  logic [287:0] fq[$];
  logic [287:0] eq[$];

  // data FIFO: 1-cycle read latency, pushes land one edge later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      pend.delete();
      bus.fifo_valid    <= 1'b0;
      bus.fifo_empty    <= 1'b1;
      bus.fifo_data_out <= '0;
    end else begin
      if (bus.fifo_pop && fq.size() != 0) begin
        bus.fifo_data_out <= fq.pop_front();
        bus.fifo_valid    <= 1'b1;
      end else begin
        bus.fifo_valid <= 1'b0;
      end
      while (pend.size() != 0) fq.push_back(pend.pop_front());
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  int cyc = 0;
  int cur_len = 0;
  int pop_cnt = 0;
  int fire_cnt = 0;
  int first_v = -1;
  int done_c = -1;
  bit gap = 1'b0;
  bit hold_v = 1'b0;
  logic [287:0] hold_d;
  logic hold_l;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (bus.fifo_pop) begin
        pop_cnt++;
        chk("pop_while_empty", bus.fifo_empty, 1'b0);
      end
      if (bus.m_wvalid && hold_v) begin
        chk("w_hold_data", {bus.m_wstrb, bus.m_wdata}, hold_d);
        chk("w_hold_last", bus.m_wlast, hold_l);
      end
      if (bus.m_wvalid && first_v < 0) first_v = cyc;
      if (bus.busy && fire_cnt > 0 && fire_cnt <= cur_len
          && !bus.m_wvalid) gap = 1'b1;
      if (bus.m_wvalid && bus.m_wready) begin
        fire_cnt++;
        if (eq.size() == 0) begin
          chk("w_extra_beat", 1'b1, 1'b0);
        end else begin
          chk("w_data", {bus.m_wstrb, bus.m_wdata}, eq.pop_front());
          chk("w_last", bus.m_wlast, fire_cnt == cur_len + 1);
        end
      end
      if (bus.fifo_pop || (bus.m_wvalid && bus.m_wready))
        chk("occ_le2", (pop_cnt - fire_cnt) <= 2, 1'b1);
      if (bus.burst_done && done_c < 0) done_c = cyc;
      hold_v = bus.m_wvalid && !bus.m_wready;
      hold_d = {bus.m_wstrb, bus.m_wdata};
      hold_l = bus.m_wlast;
    end
  end

  function automatic logic [287:0] mk(int i);
    logic [255:0] d;
    logic [31:0] s;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    s = (i % 5 == 4) ? 32'h0 : $urandom;
    return {s, d};
  endfunction

  task automatic push_n(int n);
    logic [287:0] e;
    for (int i = 0; i < n; i++) begin
      e = mk(i);
      pend.push_back(e);
      eq.push_back(e);
    end
  endtask

  task automatic clr_mon(int len);
    pop_cnt  = 0;
    fire_cnt = 0;
    first_v  = -1;
    done_c   = -1;
    gap      = 1'b0;
    cur_len  = len;
  endtask

  // issue a command; returns negedge index just before the accept edge
  task automatic start_cmd(int len, output int base);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'(len);
    @(negedge clk); #1;
    base = cyc;
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  typedef struct {
    int len;
    int prefill;
    int refill_at;
    int refill_n;
    int rdy_pct;
    int exp_done;
    int exp_gap;
    int exp_first;
  } vec_t;

  task automatic run_burst(vec_t v, string nm);
    int base;
    clr_mon(v.len);
    push_n(v.prefill);
    repeat (2) @(posedge clk);
    start_cmd(v.len, base);
    for (int k = 0; k < 4000; k++) begin
      if (done_c >= 0) break;
      bus.m_wready = (v.rdy_pct >= 100) ? 1'b1
                   : 1'($urandom_range(0, 1));
      if (v.refill_n > 0 && k == v.refill_at) push_n(v.refill_n);
      @(posedge clk); #1;
    end
    bus.m_wready = 1'b1;
    chk({nm, "_done_seen"}, done_c >= 0, 1'b1);
    chk({nm, "_pops"}, pop_cnt, v.len + 1);
    chk({nm, "_beats"}, fire_cnt, v.len + 1);
    chk({nm, "_left"}, eq.size(), 0);
    if (v.exp_done > 0)
      chk({nm, "_done_cyc"}, done_c - base, v.exp_done);
    if (v.exp_first > 0)
      chk({nm, "_first_cyc"}, first_v - base, v.exp_first);
    if (v.exp_gap >= 0)
      chk({nm, "_gap"}, gap, v.exp_gap[0]);
    chk({nm, "_done_pulse"}, bus.burst_done, 1'b0);
    chk({nm, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({nm, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({nm, "_pop"}, bus.fifo_pop, 1'b0);
    chk({nm, "_wvalid"}, bus.m_wvalid, 1'b0);
    chk({nm, "_wlast"}, bus.m_wlast, 1'b0);
    chk({nm, "_wdata"}, bus.m_wdata, 256'h0);
    chk({nm, "_wstrb"}, bus.m_wstrb, 32'h0);
    chk({nm, "_done"}, bus.burst_done, 1'b0);
    chk({nm, "_busy"}, bus.busy, 1'b0);
  endtask

  vec_t vt[5];
  int   base;

  initial begin
    vt[0] = '{0,   1,   -1, 0, 100, 4,   0,  3};
    vt[1] = '{15,  16,  -1, 0, 100, 19,  0,  3};
    vt[2] = '{31,  32,  -1, 0, 50,  0,   -1, 3};
    vt[3] = '{7,   4,   10, 4, 100, 0,   1,  3};
    vt[4] = '{255, 256, -1, 0, 100, 259, 0,  3};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.m_wready  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_wready = 1'b1;

    for (int i = 0; i < 5; i++)
      run_burst(vt[i], $sformatf("vec%0d", i));

    // reset in the middle of a 16-beat burst
    clr_mon(15);
    push_n(16);
    repeat (2) @(posedge clk);
    start_cmd(15, base);
    for (int k = 0; k < 100; k++) begin
      if (fire_cnt >= 5) break;
      @(posedge clk); #1;
    end
    chk("mid_beats_before_rst", fire_cnt, 5);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    eq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_burst(vt[1], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
